// File: rtl/img_pkg.sv
// img_pkg: image geometry, bus widths and the state encoding shared by the
// start/done image engines that sit behind the control unit.
package img_pkg;

    localparam int SRC_W_DEF   = 320;
    localparam int SRC_H_DEF   = 240;
    localparam int SRC_ADDR_W  = 17;
    localparam int DEST_ADDR_W = 19;
    localparam int PIX_W       = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_W0,
        ST_W1,
        ST_W2,
        ST_W3,
        ST_DONE
    } engine_state_e;

    // Quadrant of the 2x2 dest block written in a given write state:
    // bit 0 selects the right column, bit 1 selects the lower row.
    function automatic logic [1:0] quad_of(input engine_state_e s);
        case (s)
            ST_W1:   return 2'd1;
            ST_W2:   return 2'd2;
            ST_W3:   return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/zoom_addr_gen.sv
// zoom_addr_gen: source pixel x/y counters plus the source address and the
// dest address of the selected quadrant of the current 2x2 block.
module zoom_addr_gen
    import img_pkg::*;
#(
    parameter int SRC_W = SRC_W_DEF,
    parameter int SRC_H = SRC_H_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   advance,
    input  logic [1:0]             quad,
    output logic                   last_pix,
    output logic [SRC_ADDR_W-1:0]  src_addr,
    output logic [DEST_ADDR_W-1:0] dest_addr
);
    localparam int XW = (SRC_W > 1) ? $clog2(SRC_W) : 1;
    localparam int YW = (SRC_H > 1) ? $clog2(SRC_H) : 1;
    localparam logic [XW-1:0]          X_LAST    = XW'(SRC_W - 1);
    localparam logic [YW-1:0]          Y_LAST    = YW'(SRC_H - 1);
    localparam logic [DEST_ADDR_W-1:0] DEST_ROW  = DEST_ADDR_W'(2 * SRC_W);
    localparam logic [DEST_ADDR_W-1:0] BLOCK_ROW = DEST_ADDR_W'(4 * SRC_W);

    logic [XW-1:0]          x;
    logic [YW-1:0]          y;
    logic [DEST_ADDR_W-1:0] base;

    assign last_pix = (x == X_LAST) && (y == Y_LAST);

    // Raster-order pixel counters; they wrap back to 0 after the last pixel.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x <= '0;
            y <= '0;
        end else if (clear) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            if (x == X_LAST) begin
                x <= '0;
                y <= (y == Y_LAST) ? '0 : y + YW'(1);
            end else begin
                x <= x + XW'(1);
            end
        end
    end

    // The counters only move after the fourth write, so both addresses are
    // stable from ISSUE to W3 of each pixel.
    assign src_addr  = SRC_ADDR_W'(y) * SRC_ADDR_W'(SRC_W) + SRC_ADDR_W'(x);
    assign base      = DEST_ADDR_W'(y) * BLOCK_ROW + DEST_ADDR_W'({x, 1'b0});
    assign dest_addr = base + DEST_ADDR_W'(quad[0]) + (quad[1] ? DEST_ROW : '0);

endmodule

// File: rtl/zoom2x_engine.sv
// zoom2x_engine: start/done engine that reads each source pixel once and
// writes it to the 2x2 block it covers in the double-size frame buffer.
module zoom2x_engine
    import img_pkg::*;
#(
    parameter int SRC_W   = SRC_W_DEF,
    parameter int SRC_H   = SRC_H_DEF,
    parameter int SRC_LAT = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic                   done,
    output logic                   busy,
    output logic [SRC_ADDR_W-1:0]  src_mem_addr,
    input  logic [PIX_W-1:0]       src_mem_data_in,
    output logic [DEST_ADDR_W-1:0] dest_mem_addr,
    output logic [PIX_W-1:0]       dest_mem_data_out,
    output logic                   dest_mem_wr_en
);
    localparam logic [1:0] LAT_LAST = 2'(SRC_LAT - 1);

    engine_state_e          state;
    engine_state_e          state_nxt;
    logic [1:0]             wait_cnt;
    logic [PIX_W-1:0]       pix_reg;
    logic [1:0]             quad;
    logic                   cnt_clear;
    logic                   cnt_advance;
    logic                   capture;
    logic                   last_pix;
    logic [DEST_ADDR_W-1:0] gen_dest_addr;

    assign quad = quad_of(state);

    zoom_addr_gen #(
        .SRC_W (SRC_W),
        .SRC_H (SRC_H)
    ) u_addr_gen (
        .clk       (clk),
        .reset     (reset),
        .clear     (cnt_clear),
        .advance   (cnt_advance),
        .quad      (quad),
        .last_pix  (last_pix),
        .src_addr  (src_mem_addr),
        .dest_addr (gen_dest_addr)
    );

    // FSM state register; reset drops the engine straight back to IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next state and all outputs, decoded from the registered state.
    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt      = state;
        busy           = 1'b0;
        done           = 1'b0;
        dest_mem_wr_en = 1'b0;
        cnt_clear      = 1'b0;
        cnt_advance    = 1'b0;
        capture        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    cnt_clear = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                busy      = 1'b1;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                busy = 1'b1;
                if (wait_cnt == LAT_LAST) begin
                    capture   = 1'b1;
                    state_nxt = ST_W0;
                end
            end
            ST_W0, ST_W1, ST_W2: begin
                busy           = 1'b1;
                dest_mem_wr_en = 1'b1;
                state_nxt      = engine_state_e'(state + 3'd1);
            end
            ST_W3: begin
                busy           = 1'b1;
                dest_mem_wr_en = 1'b1;
                cnt_advance    = 1'b1;
                state_nxt      = last_pix ? ST_DONE : ST_ISSUE;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        dest_mem_addr = dest_mem_wr_en ? gen_dest_addr : '0;
    end

    // Latency counter and pixel register: q is captured SRC_LAT cycles
    // after ISSUE and ignored on every other cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
            pix_reg  <= '0;
        end else begin
            if (state == ST_ISSUE)     wait_cnt <= '0;
            else if (state == ST_WAIT) wait_cnt <= wait_cnt + 2'd1;
            if (capture) pix_reg <= src_mem_data_in;
        end
    end

    assign dest_mem_data_out = pix_reg;

endmodule

// File: tb/tb_zoom2x_engine.sv
// tb_zoom2x_engine: three engine instances (4x2 lat 1, 4x2 lat 2, 16x12
// lat 3 with a random ROM) checked against an expected zoomed image.
module tb_zoom2x_engine;

    localparam int NI      = 3;
    localparam int IMG_MAX = 768;
    localparam int ROM_C_N = 192;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] start_s;
    logic [2:0] busy_s;
    logic [2:0] done_s;
    logic [2:0] wr_s;
    logic [16:0] src_s [NI];
    logic [18:0] dst_s [NI];
    logic [7:0]  dat_s [NI];
    logic [7:0]  q_s   [NI];
    logic [7:0]  p1 [NI];
    logic [7:0]  p2 [NI];
    logic [7:0]  p3 [NI];
    logic [7:0]  rom_c [ROM_C_N];

    int n_checks = 0;
    int n_errors = 0;

    // Per-instance observations gathered by the write monitor.
    int         wr_cnt [NI];
    int         done_cnt [NI];
    int         gap_cnt [NI];
    int         since_done [NI];
    int         restart_gap [NI];
    int         first_addr [NI];
    int         last_addr [NI];
    int         oob [NI];
    logic [7:0] last_data [NI];
    bit         prev_busy [NI];
    int         hits [NI][IMG_MAX];
    logic [7:0] img [NI][IMG_MAX];

    always #5 clk = ~clk;

    zoom2x_engine #(.SRC_W(4), .SRC_H(2), .SRC_LAT(1)) u_dut_a (
        .clk(clk), .reset(reset), .start(start_s[0]), .done(done_s[0]), .busy(busy_s[0]),
        .src_mem_addr(src_s[0]), .src_mem_data_in(q_s[0]), .dest_mem_addr(dst_s[0]),
        .dest_mem_data_out(dat_s[0]), .dest_mem_wr_en(wr_s[0]));

    zoom2x_engine #(.SRC_W(4), .SRC_H(2), .SRC_LAT(2)) u_dut_b (
        .clk(clk), .reset(reset), .start(start_s[1]), .done(done_s[1]), .busy(busy_s[1]),
        .src_mem_addr(src_s[1]), .src_mem_data_in(q_s[1]), .dest_mem_addr(dst_s[1]),
        .dest_mem_data_out(dat_s[1]), .dest_mem_wr_en(wr_s[1]));

    zoom2x_engine #(.SRC_W(16), .SRC_H(12), .SRC_LAT(3)) u_dut_c (
        .clk(clk), .reset(reset), .start(start_s[2]), .done(done_s[2]), .busy(busy_s[2]),
        .src_mem_addr(src_s[2]), .src_mem_data_in(q_s[2]), .dest_mem_addr(dst_s[2]),
        .dest_mem_data_out(dat_s[2]), .dest_mem_wr_en(wr_s[2]));

    function automatic int w_of(input int i);
        return (i < 2) ? 4 : 16;
    endfunction

    function automatic int h_of(input int i);
        return (i < 2) ? 2 : 12;
    endfunction

    function automatic int l_of(input int i);
        return i + 1;
    endfunction

    function automatic logic [7:0] rom_val(input int i, input logic [16:0] a);
        if (i < 2) return a[7:0] + 8'h10;
        return (int'(a) < ROM_C_N) ? rom_c[a] : 8'hEE;
    endfunction

    // Reference image: dest (X,Y) carries source pixel (X/2, Y/2).
    function automatic logic [7:0] exp_pix(input int i, input int dx, input int dy);
        return rom_val(i, 17'((dy / 2) * w_of(i) + dx / 2));
    endfunction

    // ROM models: synchronous read, pipelined to each instance's latency.
    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            p1[i] <= rom_val(i, src_s[i]);
            p2[i] <= p1[i];
            p3[i] <= p2[i];
        end
    end
    assign q_s[0] = p1[0];
    assign q_s[1] = p2[1];
    assign q_s[2] = p3[2];

    // Write monitor: a busy rise opens a new frame and clears its record.
    initial begin
        for (int i = 0; i < NI; i++) begin
            wr_cnt[i] = 0; done_cnt[i] = 0; gap_cnt[i] = 0; since_done[i] = 0;
            restart_gap[i] = -1; first_addr[i] = -1; last_addr[i] = -1;
            oob[i] = 0; last_data[i] = 8'h00; prev_busy[i] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                if (!reset) begin
                    prev_busy[i] = 1'b0;
                end else begin
                    since_done[i]++;
                    if (busy_s[i] && !prev_busy[i]) begin
                        restart_gap[i] = since_done[i];
                        wr_cnt[i] = 0; done_cnt[i] = 0; gap_cnt[i] = 0; oob[i] = 0;
                        first_addr[i] = -1; last_addr[i] = -1;
                        for (int a = 0; a < IMG_MAX; a++) begin
                            hits[i][a] = 0;
                            img[i][a]  = 8'h00;
                        end
                    end
                    if (prev_busy[i] && !busy_s[i] && !done_s[i]) gap_cnt[i]++;
                    if (wr_s[i]) begin
                        if (wr_cnt[i] == 0) first_addr[i] = int'(dst_s[i]);
                        last_addr[i] = int'(dst_s[i]);
                        last_data[i] = dat_s[i];
                        wr_cnt[i]++;
                        if (int'(dst_s[i]) < 4 * w_of(i) * h_of(i)) begin
                            hits[i][dst_s[i]]++;
                            img[i][dst_s[i]] = dat_s[i];
                        end else begin
                            oob[i]++;
                        end
                    end
                    if (done_s[i]) begin
                        done_cnt[i]++;
                        since_done[i] = 0;
                    end
                    prev_busy[i] = busy_s[i];
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_outs(input int i, input string tag);
        check($sformatf("%s_outs[%0d]", tag, i),
              {busy_s[i], done_s[i], wr_s[i], src_s[i], dst_s[i], dat_s[i]}, 64'd0);
    endtask

    // One frame on instance i, with stray start pulses while busy; with hold
    // set, start stays high through DONE.
    task automatic run_frame(input int i, input bit hold);
        int  w, h, n, lat_exp, k, bad;
        bit  seen;
        w = w_of(i);
        h = h_of(i);
        n = 4 * w * h;
        lat_exp = w * h * (5 + l_of(i)) + 1;
        repeat ($urandom_range(0, 4)) @(posedge clk);
        @(posedge clk); #1;
        start_s[i] = 1'b1;
        @(posedge clk); #1;
        seen = 1'b0;
        k = 0;
        while (!seen && k < lat_exp + 20) begin
            k++;
            if (done_s[i]) begin
                seen = 1'b1;
                start_s[i] = hold;
            end else begin
                start_s[i] = hold || k == 10 || k == 20 ||
                             (i == 2 && $urandom_range(0, 7) == 0);
                @(posedge clk); #1;
            end
        end
        start_s[i] = hold;
        check($sformatf("done_seen[%0d]", i), seen, 1);
        check($sformatf("done_cycle[%0d]", i), k, lat_exp);
        @(negedge clk); #1;
        check($sformatf("writes[%0d]", i), wr_cnt[i], n);
        check($sformatf("done_pulses[%0d]", i), done_cnt[i], 1);
        check($sformatf("busy_gaps[%0d]", i), gap_cnt[i], 0);
        check($sformatf("first_addr[%0d]", i), first_addr[i], 0);
        check($sformatf("last_addr[%0d]", i), last_addr[i], n - 1);
        check($sformatf("last_data[%0d]", i), last_data[i], exp_pix(i, 2 * w - 1, 2 * h - 1));
        bad = oob[i];
        for (int a = 0; a < n; a++) begin
            if (hits[i][a] != 1 || img[i][a] !== exp_pix(i, a % (2 * w), a / (2 * w))) bad++;
        end
        check($sformatf("image_bad[%0d]", i), bad, 0);
    endtask

    initial begin
        int idle_bad, k, nw;
        reset   = 1'b1;
        start_s = 3'b000;
        for (int a = 0; a < ROM_C_N; a++) rom_c[a] = 8'($urandom);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) check_outs(i, "reset");
        @(negedge clk) reset = 1'b1;

        idle_bad = 0;
        repeat (100) begin
            @(posedge clk); #1;
            if (wr_s != 3'b000 || done_s != 3'b000 || busy_s != 3'b000) idle_bad++;
        end
        check("idle_quiet", idle_bad, 0);

        run_frame(0, 1'b0);
        check("pix5_block", {img[0][18], img[0][19], img[0][26], img[0][27]}, 32'h15151515);
        run_frame(1, 1'b0);
        check("lat2_pix0", img[1][0], 8'h10);
        run_frame(2, 1'b0);

        // Start held through DONE: re-accepted on the IDLE cycle after done.
        run_frame(0, 1'b1);
        k = 0;
        while (!busy_s[0] && k < 10) begin
            @(posedge clk); #1;
            k++;
        end
        start_s[0] = 1'b0;
        check("restart_busy", busy_s[0], 1);
        @(negedge clk); #1;
        check("restart_gap", restart_gap[0], 2);

        // Reset during the 13th write of that second frame.
        nw = 0;
        k = 0;
        while (nw < 13 && k < 200) begin
            @(posedge clk); #1;
            k++;
            if (wr_s[0]) nw++;
        end
        check("write13_reached", nw, 13);
        reset = 1'b0;
        #1;
        check("mid_rst_wr_en", wr_s[0], 0);
        check("mid_rst_busy", busy_s[0], 0);
        check_outs(0, "mid_rst");
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("partial_writes", wr_cnt[0], 12);
        check("aborted_no_done", done_cnt[0], 0);
        run_frame(0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
